compute_r_bins_div_seq: RTL and testbench

Sequential signed divider that inverts the r-bin product path. It recovers the 18-bit signed bin operand from a 33-bit signed product and the 15-bit signed coefficient that produced it. It sits after the r-bin multiplier stage in compute_r_bins, where calibration and self-check logic need the original operand back. It is an iterative restoring divider with valid/ready handshakes, one operation in flight.

---
 rtl/compute_r_bins_pkg.sv | 22 ++
 rtl/compute_r_bins_div_step.sv | 29 ++
 rtl/compute_r_bins_div_seq.sv | 148 ++++++++++++++
 tb/tb_compute_r_bins_div_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_r_bins_pkg.sv
// Shared constants and types for the compute_r_bins divider slice.
// Holds the operand widths, FSM state encoding and quotient saturation values.
package compute_r_bins_pkg;

  localparam int DIVIDEND_W = 33;
  localparam int DIVISOR_W  = 15;
  localparam int QUOT_W     = DIVIDEND_W - DIVISOR_W;
  localparam int PART_W     = DIVISOR_W + 1;
  localparam int QBITS      = QUOT_W - 1;
  localparam int ITER_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [QUOT_W-1:0] QUOT_POS_SAT = 18'h1FFFF;
  localparam logic [QUOT_W-1:0] QUOT_NEG_SAT = 18'h20001;

endpackage

// File: rtl/compute_r_bins_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor magnitude when the shifted partial covers it.
module compute_r_bins_div_step
  import compute_r_bins_pkg::*;
(
  input  logic [PART_W-1:0]    partial_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor_abs,
  output logic [PART_W-1:0]    partial_out,
  output logic                 quot_bit
);

  logic [PART_W:0]   shifted;
  logic [PART_W-1:0] diff;

  // The extra top bit keeps the compare exact even if the partial is large.
  always_comb begin
    shifted = {partial_in, next_bit};
    diff    = shifted[PART_W-1:0] - {1'b0, divisor_abs};
    if (shifted >= {2'b00, divisor_abs}) begin
      partial_out = diff;
      quot_bit    = 1'b1;
    end else begin
      partial_out = shifted[PART_W-1:0];
      quot_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/compute_r_bins_div_seq.sv
// Iterative signed restoring divider recovering the r-bin operand from its product.
// Optional remainder output is built when COMPUTE_R_BINS_DIV_REM_EN is defined.
module compute_r_bins_div_seq
  import compute_r_bins_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  ovf
`ifdef COMPUTE_R_BINS_DIV_REM_EN
  ,
  output logic [DIVISOR_W-1:0]  remainder
`endif
);

  state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] dividend_abs;
  logic [DIVISOR_W-1:0]  divisor_abs;
  logic                  accept;
  logic                  dz;
  logic                  range_ovf;

  logic                  sign_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  dz_q;
  logic                  range_q;
  logic [PART_W-1:0]     partial;
  logic [QBITS-1:0]      dlow;
  logic [QBITS-1:0]      qacc;
  logic [ITER_W-1:0]     iter;

  logic [PART_W-1:0]     step_partial;
  logic                  step_qbit;

  always_comb begin
    dividend_abs = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
    divisor_abs  = divisor[DIVISOR_W-1] ? (~divisor + DIVISOR_W'(1)) : divisor;
    dz           = (divisor == '0);
    range_ovf    = (dividend_abs[DIVIDEND_W-1 -: PART_W] >= {1'b0, divisor_abs});
    accept       = in_valid && in_ready;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (iter == ITER_W'(QBITS - 1)) state_nxt = ST_FIX;
      end
      ST_FIX: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  compute_r_bins_div_step u_step (
    .partial_in  (partial),
    .next_bit    (dlow[QBITS-1]),
    .divisor_abs (dvs_q),
    .partial_out (step_partial),
    .quot_bit    (step_qbit)
  );

  // The low dividend bits sit in a shift register so each step reads its MSB.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sign_q   <= 1'b0;
      dvs_q    <= '0;
      dz_q     <= 1'b0;
      range_q  <= 1'b0;
      partial  <= '0;
      dlow     <= '0;
      qacc     <= '0;
      iter     <= '0;
      quotient <= '0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        sign_q  <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
        dvs_q   <= divisor_abs;
        dz_q    <= dz;
        range_q <= range_ovf;
        partial <= dividend_abs[DIVIDEND_W-1 -: PART_W];
        dlow    <= dividend_abs[QBITS-1:0];
        qacc    <= '0;
        iter    <= '0;
      end else if (state == ST_RUN) begin
        partial <= step_partial;
        qacc    <= {qacc[QBITS-2:0], step_qbit};
        dlow    <= {dlow[QBITS-2:0], 1'b0};
        iter    <= iter + ITER_W'(1);
      end else if (state == ST_FIX) begin
        if (dz_q) begin
          quotient <= '0;
          ovf      <= 1'b1;
        end else if (range_q) begin
          quotient <= sign_q ? QUOT_NEG_SAT : QUOT_POS_SAT;
          ovf      <= 1'b1;
        end else begin
          quotient <= sign_q ? (QUOT_W'(0) - {1'b0, qacc}) : {1'b0, qacc};
          ovf      <= 1'b0;
        end
      end
    end
  end

`ifdef COMPUTE_R_BINS_DIV_REM_EN
  logic sign_r;

  // Remainder takes the dividend sign; a zero divisor forces it to zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sign_r    <= 1'b0;
      remainder <= '0;
    end else begin
      if (accept) begin
        sign_r <= dividend[DIVIDEND_W-1];
      end
      if (state == ST_FIX) begin
        if (dz_q) remainder <= '0;
        else if (sign_r) remainder <= DIVISOR_W'(0) - partial[DIVISOR_W-1:0];
        else remainder <= partial[DIVISOR_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_compute_r_bins_div_seq.sv
// Directed self-checking bench for compute_r_bins_div_seq.
// Remainder checks are compiled in only with COMPUTE_R_BINS_DIV_REM_EN.
module tb_compute_r_bins_div_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] dividend = '0;
  logic [14:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] quotient;
  logic        ovf;
`ifdef COMPUTE_R_BINS_DIV_REM_EN
  logic [14:0] remainder;
`endif

  int checks = 0;
  int failures = 0;

  compute_r_bins_div_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .ovf       (ovf)
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    ,
    .remainder (remainder)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Presents one operand pair and counts edges until out_valid is seen.
  task automatic run_op(input logic [32:0] dvd, input logic [14:0] dvs, output int lat);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    #12;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (quotient !== 18'd0) begin failures++; $display("[TB] FAIL reset_quotient: got %h expected 0", quotient); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    checks++;
    if (remainder !== 15'd0) begin failures++; $display("[TB] FAIL reset_remainder: got %h expected 0", remainder); end
`endif
  endtask

  task automatic test_exact();
    int lat;
    run_op(-33'sd3962745, -15'sd321, lat);
    checks++;
    if (lat !== 18) begin failures++; $display("[TB] FAIL exact_latency: got %0d expected 18", lat); end
    checks++;
    if (quotient !== 18'd12345) begin failures++; $display("[TB] FAIL exact_quotient: got %h expected %h", quotient, 18'd12345); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL exact_ovf: got %b expected 0", ovf); end
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    checks++;
    if (remainder !== 15'd0) begin failures++; $display("[TB] FAIL exact_remainder: got %h expected 0", remainder); end
`endif
    accept_result();
  endtask

  task automatic test_small();
    int lat;
    run_op(33'd1000, 15'd7, lat);
    checks++;
    if (quotient !== 18'd142) begin failures++; $display("[TB] FAIL pos_quotient: got %h expected %h", quotient, 18'd142); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL pos_ovf: got %b expected 0", ovf); end
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    checks++;
    if (remainder !== 15'd6) begin failures++; $display("[TB] FAIL pos_remainder: got %h expected 6", remainder); end
`endif
    accept_result();
    run_op(-33'sd1000, 15'd7, lat);
    checks++;
    if (quotient !== 18'h3FF72) begin failures++; $display("[TB] FAIL neg_quotient: got %h expected 3ff72", quotient); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL neg_ovf: got %b expected 0", ovf); end
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    checks++;
    if (remainder !== 15'h7FFA) begin failures++; $display("[TB] FAIL neg_remainder: got %h expected 7ffa", remainder); end
`endif
    accept_result();
  endtask

  task automatic test_range();
    int lat;
    run_op(33'd1048576, 15'd3, lat);
    checks++;
    if (quotient !== 18'h1FFFF) begin failures++; $display("[TB] FAIL range_pos_quotient: got %h expected 1ffff", quotient); end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL range_pos_ovf: got %b expected 1", ovf); end
    checks++;
    if (lat !== 18) begin failures++; $display("[TB] FAIL range_latency: got %0d expected 18", lat); end
    accept_result();
    run_op(33'd1048576, -15'sd3, lat);
    checks++;
    if (quotient !== 18'h20001) begin failures++; $display("[TB] FAIL range_neg_quotient: got %h expected 20001", quotient); end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL range_neg_ovf: got %b expected 1", ovf); end
    accept_result();
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(33'd500, 15'd0, lat);
    checks++;
    if (lat !== 18) begin failures++; $display("[TB] FAIL dz_latency: got %0d expected 18", lat); end
    checks++;
    if (quotient !== 18'd0) begin failures++; $display("[TB] FAIL dz_quotient: got %h expected 0", quotient); end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL dz_ovf: got %b expected 1", ovf); end
`ifdef COMPUTE_R_BINS_DIV_REM_EN
    checks++;
    if (remainder !== 15'd0) begin failures++; $display("[TB] FAIL dz_remainder: got %h expected 0", remainder); end
`endif
    accept_result();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    run_op(33'd1000, 15'd7, lat);
    dividend = 33'd50;
    divisor  = 15'd5;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 18'd142 || ovf !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0 (last q=%h iv=%b ir=%b)", bad, quotient, out_valid, in_ready); end
    in_valid = 1'b0;
    accept_result();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_release_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_release_out_valid: got %b expected 0", out_valid); end
    repeat (20) @(posedge ap_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_ignored_op: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    dividend = 33'd1000;
    divisor  = 15'd7;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid_low: got %b expected 0", out_valid); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
    run_op(-33'sd1000, 15'd7, lat);
    checks++;
    if (lat !== 18) begin failures++; $display("[TB] FAIL midrst_fresh_latency: got %0d expected 18", lat); end
    checks++;
    if (quotient !== 18'h3FF72) begin failures++; $display("[TB] FAIL midrst_fresh_quotient: got %h expected 3ff72", quotient); end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    run_op(33'd50, 15'd5, lat);
    checks++;
    if (quotient !== 18'd10 || lat !== 18) begin failures++; $display("[TB] FAIL b2b_first: got q=%h lat=%0d expected q=00a lat=18", quotient, lat); end
    @(posedge ap_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
    run_op(-33'sd50, 15'd5, lat);
    checks++;
    if (quotient !== 18'h3FFF6 || lat !== 18) begin failures++; $display("[TB] FAIL b2b_second: got q=%h lat=%0d expected q=3fff6 lat=18", quotient, lat); end
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_small();
    test_range();
    test_div_zero();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
